// File: rtl/median_pkg.sv
// Shared types and constants for the 9-tap median sequencer.
package median_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SORT  = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } med_state_t;

    localparam int MED_NPIX  = 9;
    localparam int MED_NDROP = 4;
    // Cycles from the last pixel-valid cycle to the DSO pulse.
    localparam int MED_LAT   = 41;

endpackage

// File: rtl/median_if.sv
// Handshake between pixel source, median sequencer and median datapath.
interface median_if;

    logic DSI;
    logic DSI_MED;
    logic BYP;
    logic BUSY;
    logic DSO;

    modport master (
        input  DSI,
        output DSI_MED,
        output BYP,
        output BUSY,
        output DSO
    );

    modport slave (
        output DSI,
        input  DSI_MED,
        input  BYP,
        input  BUSY,
        input  DSO
    );

endinterface

// File: rtl/median_ctrl.sv
// Sequencer for the 9-tap median datapath: load window, bubble out the four
// largest values, run the final max pass, then flag the median on DSO.
module median_ctrl
    import median_pkg::*;
#(
    parameter int NPIX  = MED_NPIX,
    parameter int NDROP = MED_NDROP
) (
    input  logic     clk,
    input  logic     rst,
    median_if.master bus
);

    localparam logic [3:0] CYC_LAST  = 4'(NPIX - 1);
    localparam logic [3:0] FIN_LAST  = 4'(NDROP - 1);
    localparam logic [2:0] PASS_LAST = 3'(NDROP - 1);

    med_state_t state_q, state_d;
    logic [3:0] cyc_q, cyc_d;
    logic [2:0] pass_q, pass_d;

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                cyc_d  = 4'd0;
                pass_d = 3'd0;
                if (bus.DSI) begin
                    state_d = LOAD;
                    cyc_d   = 4'd1;
                end
            end
            LOAD: begin
                if (!bus.DSI) begin
                    // A gap in the burst abandons the partial window.
                    state_d = IDLE;
                    cyc_d   = 4'd0;
                    pass_d  = 3'd0;
                end else if (cyc_q == CYC_LAST) begin
                    state_d = SORT;
                    cyc_d   = 4'd0;
                    pass_d  = 3'd0;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            SORT: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d = 4'd0;
                    if (pass_q == PASS_LAST) begin
                        state_d = FINAL;
                        pass_d  = 3'd0;
                    end else begin
                        pass_d = pass_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            FINAL: begin
                if (cyc_q == FIN_LAST) begin
                    state_d = DONE;
                    cyc_d   = 4'd0;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            DONE: begin
                pass_d = 3'd0;
                if (bus.DSI) begin
                    state_d = LOAD;
                    cyc_d   = 4'd1;
                end else begin
                    state_d = IDLE;
                    cyc_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 4'd0;
                pass_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= 4'd0;
            pass_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            pass_q  <= pass_d;
        end
    end

    // Pass p compares the first 8-p positions, then bypasses the p+1 already-discarded maxima.
    always_comb begin
        bus.BYP  = 1'b1;
        bus.BUSY = 1'b0;
        bus.DSO  = 1'b0;
        case (state_q)
            SORT: begin
                bus.BUSY = 1'b1;
                bus.BYP  = (cyc_q < (CYC_LAST - {1'b0, pass_q})) ? 1'b0 : 1'b1;
            end
            FINAL: begin
                bus.BUSY = 1'b1;
                bus.BYP  = 1'b0;
            end
            DONE: begin
                bus.DSO = 1'b1;
            end
            default: begin
                bus.BYP = 1'b1;
            end
        endcase
    end

    // Load strobe is masked during reset so a held DSI cannot disturb the datapath.
    assign bus.DSI_MED = bus.DSI && !rst &&
                         ((state_q == IDLE) || (state_q == LOAD) || (state_q == DONE));

endmodule
